// File: rtl/uart_rx_frame.sv
`timescale 1ns/1ps
// uart_rx_frame
//   Oversampled UART frame receiver with a valid/ready output hold register.
//   Each line bit is sampled once, at its centre. The start bit is checked
//   half a bit after the falling edge, and later bits are sampled at full-bit
//   spacing from that point. The receiver returns to IDLE at the centre of
//   the last stop bit, so back-to-back frames need no idle bits between them.
//
//   Optional feature: define UART_RX_PARITY_EN to expect one parity bit
//   between the data and stop bits. Without it, parity_err is tied to 0 and
//   parity_odd is ignored.
//
// Ports
//   baud_clk    in   oversampling clock; all logic uses its rising edge
//   reset_n     in   asynchronous active-low reset
//   data_tx     in   serial line; idles high and sends LSB first. It must
//                    already be synchronous to baud_clk.
//   parity_odd  in   1 = odd parity, 0 = even parity
//   rx_ready    in   consumer accepts the held frame
//   rx_data     out  received payload
//   rx_valid    out  rx_data and the error flags are valid
//   active_flag out  a frame is being received
//   frame_err   out  a stop bit was sampled low in the held frame
//   parity_err  out  parity mismatch in the held frame
//   overrun_err out  one-cycle pulse when a completed frame is dropped
//
// States
//   S_IDLE   | waiting for a low line level after the line was seen high
//   S_START  | waiting half a bit, then confirming the start bit is low
//   S_DATA   | sampling DATA_BITS payload bits, LSB first
//   S_PARITY | sampling the parity bit (UART_RX_PARITY_EN only)
//   S_STOP   | sampling STOP_BITS stop bits
module uart_rx_frame #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                 baud_clk,
  input  logic                 reset_n,
  input  logic                 data_tx,
  input  logic                 parity_odd,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 active_flag,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err
);

  localparam int TW = $clog2(OVERSAMPLE) + 1;
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BITS_M1 = BW'(DATA_BITS - 1);
  localparam logic          STOP_M1 = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd4,
`endif
    S_STOP   = 3'd3
  } state_t;

  state_t               state_q;
  logic [TW-1:0]        tick_q;
  logic [BW-1:0]        bit_q;
  logic                 stop_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 ferr_stage_q;
  logic                 done_q;
  logic                 arm_q;
  logic                 active_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 frame_err_q;
  logic                 overrun_q;
`ifdef UART_RX_PARITY_EN
  logic                 perr_stage_q;
  logic                 parity_err_q;
  logic                 perr_d;

  // The received parity bit must equal the XOR of the payload, inverted
  // when odd parity is selected.
  assign perr_d = data_tx ^ (^shift_q) ^ parity_odd;
`endif

  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      tick_q       <= '0;
      bit_q        <= '0;
      stop_q       <= 1'b0;
      shift_q      <= '0;
      ferr_stage_q <= 1'b0;
      done_q       <= 1'b0;
      arm_q        <= 1'b0;
      active_q     <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_stage_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      done_q    <= 1'b0;
      overrun_q <= 1'b0;

      case (state_q)
        // arm_q makes sure a start is only taken after the line has been seen
        // high. A line still held low when reset is released, or after a bad
        // stop bit, is therefore not taken as a new frame.
        S_IDLE: begin
          if (data_tx) begin
            arm_q <= 1'b1;
          end else if (arm_q) begin
            state_q  <= S_START;
            tick_q   <= '0;
            active_q <= 1'b1;
            arm_q    <= 1'b0;
          end
        end

        S_START: begin
          if (tick_q == HALF_M1) begin
            tick_q <= '0;
            if (data_tx) begin
              state_q  <= S_IDLE;
              active_q <= 1'b0;
              arm_q    <= 1'b1;
            end else begin
              state_q <= S_DATA;
              bit_q   <= '0;
            end
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end

        S_DATA: begin
          if (tick_q == FULL_M1) begin
            tick_q  <= '0;
            shift_q <= {data_tx, shift_q[DATA_BITS-1:1]};
            if (bit_q == BITS_M1) begin
              bit_q        <= '0;
              stop_q       <= 1'b0;
              ferr_stage_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
              state_q      <= S_PARITY;
`else
              state_q      <= S_STOP;
`endif
            end else begin
              bit_q <= bit_q + BW'(1);
            end
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (tick_q == FULL_M1) begin
            tick_q       <= '0;
            perr_stage_q <= perr_d;
            state_q      <= S_STOP;
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
`endif

        S_STOP: begin
          if (tick_q == FULL_M1) begin
            tick_q       <= '0;
            ferr_stage_q <= ferr_stage_q | ~data_tx;
            if (stop_q == STOP_M1) begin
              // Leave at the stop-bit centre so that the next start edge can
              // follow immediately. done_q hands the frame to the output
              // stage on the next cycle.
              state_q  <= S_IDLE;
              stop_q   <= 1'b0;
              active_q <= 1'b0;
              done_q   <= 1'b1;
              arm_q    <= data_tx;
            end else begin
              stop_q <= 1'b1;
            end
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end

        default: begin
          state_q  <= S_IDLE;
          tick_q   <= '0;
          active_q <= 1'b0;
        end
      endcase

      // The output register accepts a new frame when it is empty or is being
      // read in this same cycle. Otherwise the new frame is dropped and the
      // held frame is kept.
      if (done_q) begin
        if (!rx_valid_q || rx_ready) begin
          rx_data_q    <= shift_q;
          rx_valid_q   <= 1'b1;
          frame_err_q  <= ferr_stage_q;
`ifdef UART_RX_PARITY_EN
          parity_err_q <= perr_stage_q;
`endif
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q   <= 1'b0;
        frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err_q <= 1'b0;
`endif
      end
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign active_flag = active_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = parity_err_q;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd;
  assign parity_err        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
`timescale 1ns/1ps
module tb_uart_rx_frame;

  localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  // Cycle offsets counted from the first edge at which the line is seen low.
  localparam int LAT   = 153 + OS * P;
  localparam int FRAME = OS * (10 + P);

  logic       baud_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       data_tx = 1'b1;
  logic       parity_odd = 1'b0;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, active_flag, frame_err, parity_err, overrun_err;
  logic       unused_par;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 baud_clk = ~baud_clk;

  uart_rx_frame #(.DATA_BITS(8), .OVERSAMPLE(OS), .STOP_BITS(1)) dut (
    .baud_clk    (baud_clk),
    .reset_n     (reset_n),
    .data_tx     (data_tx),
    .parity_odd  (parity_odd),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .active_flag (active_flag),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .overrun_err (overrun_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge baud_clk);
    #1;
  endtask

  function automatic logic par_of(input logic [7:0] d);
    return (^d) ^ parity_odd;
  endfunction

  // Call 1 ns after a rising edge. The next edge is then edge 0 of the frame.
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_v);
    data_tx = 1'b0;
    tick(OS);
    for (int i = 0; i < 8; i++) begin
      data_tx = d[i];
      tick(OS);
    end
`ifdef UART_RX_PARITY_EN
    data_tx = par_v;
    tick(OS);
`else
    unused_par = par_v;
`endif
    data_tx = stop_v;
    tick(OS);
    data_tx = 1'b1;
  endtask

  task automatic accept();
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat, ovr_n, ovr_at;
    logic act0, act7, act8, saw_v, saw_e, v_s, ovr_s, act_b;
    logic [7:0] d_s;
    unused_par = 1'b0;

    tick(3);
    check("rst_valid", 32'(rx_valid), 0);
    check("rst_data", 32'(rx_data), 0);
    check("rst_active", 32'(active_flag), 0);
    check("rst_ferr", 32'(frame_err), 0);
    check("rst_perr", 32'(parity_err), 0);
    check("rst_ovr", 32'(overrun_err), 0);
    reset_n = 1'b1;
    tick(5);

    // Receive 0xA5: check the latency and that the frame is held.
    lat = -1; act0 = 1'b0;
    fork
      send_frame(8'hA5, 1'b1, par_of(8'hA5));
      for (int k = 0; k < LAT + 20; k++) begin
        @(posedge baud_clk); #1;
        if (k == 0) act0 = active_flag;
        if (rx_valid && lat < 0) lat = k;
      end
    join
    check("a5_latency", 32'(lat), 32'(LAT));
    check("a5_active0", 32'(act0), 1);
    check("a5_data", 32'(rx_data), 32'h A5);
    check("a5_ferr", 32'(frame_err), 0);
    check("a5_perr", 32'(parity_err), 0);
    check("a5_active_end", 32'(active_flag), 0);
    tick(20);
    check("a5_hold_valid", 32'(rx_valid), 1);
    check("a5_hold_data", 32'(rx_data), 32'h A5);
    accept();
    check("a5_accept_valid", 32'(rx_valid), 0);

    // A 4-cycle low glitch is rejected as a false start.
    act7 = 1'b0; act8 = 1'b1; saw_v = 1'b0; saw_e = 1'b0;
    data_tx = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge baud_clk); #1;
      if (k == 3) data_tx = 1'b1;
      if (k == 7) act7 = active_flag;
      if (k == 8) act8 = active_flag;
      saw_v |= rx_valid;
      saw_e |= frame_err | parity_err | overrun_err;
    end
    check("glitch_act_pre", 32'(act7), 1);
    check("glitch_act_post", 32'(act8), 0);
    check("glitch_valid", 32'(saw_v), 0);
    check("glitch_err", 32'(saw_e), 0);

    // Receive 0x3C with the stop bit driven low.
    send_frame(8'h3C, 1'b0, par_of(8'h3C));
    check("3c_valid", 32'(rx_valid), 1);
    check("3c_data", 32'(rx_data), 32'h3C);
    check("3c_ferr", 32'(frame_err), 1);
    check("3c_perr", 32'(parity_err), 0);
    tick(10);
    accept();
    check("3c_ferr_clr", 32'(frame_err), 0);
    check("3c_valid_clr", 32'(rx_valid), 0);

    // Overrun: send 0x11 and 0x22 back-to-back while rx_ready stays 0.
    ovr_n = 0; ovr_at = -1;
    fork
      begin
        send_frame(8'h11, 1'b1, par_of(8'h11));
        send_frame(8'h22, 1'b1, par_of(8'h22));
      end
      for (int k = 0; k < 2 * FRAME + 10; k++) begin
        @(posedge baud_clk); #1;
        if (overrun_err) begin
          ovr_n++;
          if (ovr_at < 0) ovr_at = k;
        end
      end
    join
    check("ovr_count", 32'(ovr_n), 1);
    check("ovr_cycle", 32'(ovr_at), 32'(FRAME + LAT));
    check("ovr_data", 32'(rx_data), 32'h11);
    check("ovr_valid", 32'(rx_valid), 1);
    accept();

    // A new frame completes in the same cycle that the held frame is accepted.
    send_frame(8'h5A, 1'b1, par_of(8'h5A));
    check("sim_held", 32'(rx_data), 32'h5A);
    v_s = 1'b0; d_s = 8'h00; ovr_s = 1'b0;
    fork
      send_frame(8'hC3, 1'b1, par_of(8'hC3));
      for (int k = 0; k < LAT + 5; k++) begin
        @(posedge baud_clk); #1;
        if (k == LAT - 1) rx_ready = 1'b1;
        if (k == LAT) begin
          rx_ready = 1'b0;
          v_s = rx_valid;
          d_s = rx_data;
        end
        ovr_s |= overrun_err;
      end
    join
    check("sim_valid", 32'(v_s), 1);
    check("sim_data", 32'(d_s), 32'hC3);
    check("sim_no_ovr", 32'(ovr_s), 0);
    accept();

    // Assert reset during data bit 3 of 0xFF.
    saw_v = 1'b0; act_b = 1'b0;
    fork
      send_frame(8'hFF, 1'b1, par_of(8'hFF));
      for (int k = 0; k < FRAME + 5; k++) begin
        @(posedge baud_clk); #1;
        if (k == 69) act_b = active_flag;
        if (k == 70) begin
          #2 reset_n = 1'b0;
          #1;
          check("rstmid_active", 32'(active_flag), 0);
          check("rstmid_data", 32'(rx_data), 0);
          check("rstmid_valid", 32'(rx_valid), 0);
          check("rstmid_errs", 32'({frame_err, parity_err, overrun_err}), 0);
        end
        if (k == 72) reset_n = 1'b1;
        if (k > 72) saw_v |= rx_valid;
      end
    join
    check("rstmid_active_before", 32'(act_b), 1);
    check("rstmid_no_frame", 32'(saw_v), 0);
    tick(5);
    send_frame(8'h55, 1'b1, par_of(8'h55));
    check("post_rst_valid", 32'(rx_valid), 1);
    check("post_rst_data", 32'(rx_data), 32'h55);
    check("post_rst_ferr", 32'(frame_err), 0);
    accept();

`ifdef UART_RX_PARITY_EN
    // 0x07 has three 1 bits, so even parity needs a parity bit of 1.
    parity_odd = 1'b0;
    tick(5);
    send_frame(8'h07, 1'b1, 1'b0);
    check("par_even_bad", 32'(parity_err), 1);
    check("par_even_bad_data", 32'(rx_data), 32'h07);
    accept();
    check("par_clr", 32'(parity_err), 0);
    send_frame(8'h07, 1'b1, 1'b1);
    check("par_even_good", 32'(parity_err), 0);
    accept();
    parity_odd = 1'b1;
    tick(5);
    send_frame(8'h07, 1'b1, 1'b0);
    check("par_odd_good", 32'(parity_err), 0);
    accept();
`endif

    tick(5);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
